// File: rtl/hazard_unit.sv
// hazard_unit: hazard, stall and forwarding controller for the in-order hart.
// Compares the instruction in ID against every back-end stage. A per-stage
// bubble mask keeps bubbles out of the comparison. Produces combinational
// stalls and registered per-operand forwarding selects.
// Optional feature macro: HZ_BRANCH_FW_EN. When it is defined, branch, jalr
// and store operands forward normally. When it is undefined, any match by
// those consumers stalls until the producer has retired.
module hazard_unit #(
    parameter int NBE    = 3,
    parameter int LD_STG = 2,
    parameter int SW     = (NBE > 2) ? $clog2(NBE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ir_id,
    input  logic [NBE*32-1:0] ir_be,
    input  logic              bus_busy,
    input  logic              amo_req,
    input  logic              amo_ack,
    output logic              stall_if,
    output logic              stall_fe,
    output logic [NBE-1:0]    stall_be,
    output logic              fw_a_en,
    output logic [SW-1:0]     fw_a_sel,
    output logic              fw_b_en,
    output logic [SW-1:0]     fw_b_sel
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // rs1 carries immediate bits for the U/J formats
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_RW || op == OP_BRANCH || op == OP_STORE);
    endfunction

    // Branch, jalr and store resolve in EX without a forwarding path
    function automatic logic is_ctl_consumer(input logic [6:0] op);
        return (op == OP_BRANCH || op == OP_JALR || op == OP_STORE);
    endfunction

    logic           stall_all;
    logic           hz;
    logic [NBE-1:0] bub;

    logic [6:0]     id_op;
    logic [4:0]     id_rs1;
    logic [4:0]     id_rs2;
    logic           use_a;
    logic           use_b;

    logic [NBE-1:0] prod_vld;
    logic [NBE-1:0] prod_late;
    logic [4:0]     prod_rd [NBE];

    logic           a_match;
    logic [SW-1:0]  a_k;
    logic           a_late;
    logic           b_match;
    logic [SW-1:0]  b_k;
    logic           b_late;

    logic [9:0]        unused_id_bits;
    logic [NBE*20-1:0] unused_be_hi;

    assign id_op  = ir_id[6:0];
    assign id_rs1 = ir_id[19:15];
    assign id_rs2 = ir_id[24:20];
    assign use_a  = uses_rs1(id_op);
    assign use_b  = uses_rs2(id_op);

    assign unused_id_bits = {ir_id[31:25], ir_id[14:12]};

    assign stall_all = !rst_n || bus_busy || (amo_req && !amo_ack);

    // Decode each back-end stage into a producer record (valid, rd, late load)
    always_comb begin
        for (int k = 0; k < NBE; k++) begin
            prod_rd[k]   = ir_be[k*32+7 +: 5];
            prod_vld[k]  = !bub[k]
                           && ir_be[k*32 +: 7] != OP_BRANCH
                           && ir_be[k*32 +: 7] != OP_STORE
                           && ir_be[k*32+7 +: 5] != 5'd0;
            prod_late[k] = (ir_be[k*32 +: 7] == OP_LOAD) && (k < LD_STG);
            unused_be_hi[k*20 +: 20] = ir_be[k*32+12 +: 20];
        end
    end

    // Youngest matching producer per operand: scan oldest to youngest, last hit wins
    always_comb begin
        a_match = 1'b0;
        a_k     = '0;
        a_late  = 1'b0;
        b_match = 1'b0;
        b_k     = '0;
        b_late  = 1'b0;
        for (int k = NBE - 1; k >= 0; k--) begin
            if (prod_vld[k] && prod_rd[k] == id_rs1) begin
                a_match = 1'b1;
                a_k     = SW'(k);
                a_late  = prod_late[k];
            end
            if (prod_vld[k] && prod_rd[k] == id_rs2) begin
                b_match = 1'b1;
                b_k     = SW'(k);
                b_late  = prod_late[k];
            end
        end
    end

    // Hazard: a used operand whose youngest producer cannot be forwarded yet
    always_comb begin
        hz = (use_a && a_match && a_late) || (use_b && b_match && b_late);
`ifndef HZ_BRANCH_FW_EN
        if (is_ctl_consumer(id_op) && ((use_a && a_match) || (use_b && b_match))) begin
            hz = 1'b1;
        end
`endif
    end

    assign stall_fe = stall_all || hz;
    assign stall_if = stall_fe || amo_req;
    assign stall_be = {NBE{stall_all}} | bub;

    // Bubble mask: a held ID injects a bubble into EX; global stalls freeze it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bub <= '1;
        end else if (!stall_all) begin
            bub <= {bub[NBE-2:0], hz};
        end
    end

    // Forwarding selects for the instruction about to enter EX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fw_a_en  <= 1'b0;
            fw_a_sel <= '0;
            fw_b_en  <= 1'b0;
            fw_b_sel <= '0;
        end else if (!stall_all) begin
            if (hz) begin
                fw_a_en <= 1'b0;
                fw_b_en <= 1'b0;
            end else begin
                fw_a_en <= a_match;
                fw_b_en <= b_match;
                if (a_match) begin
                    fw_a_sel <= a_k;
                end
                if (b_match) begin
                    fw_b_sel <= b_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, directed multi-cycle sequences and a
// randomized run against a pipeline-level reference model.
module tb_hazard_unit;

    localparam int NBE    = 3;
    localparam int LD_STG = 2;
    localparam int SW     = 2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef HZ_BRANCH_FW_EN
    localparam bit BRFW = 1'b1;
`else
    localparam bit BRFW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       ir_id;
    logic [NBE*32-1:0] ir_be;
    logic              bus_busy;
    logic              amo_req;
    logic              amo_ack;
    logic              stall_if;
    logic              stall_fe;
    logic [NBE-1:0]    stall_be;
    logic              fw_a_en;
    logic [SW-1:0]     fw_a_sel;
    logic              fw_b_en;
    logic [SW-1:0]     fw_b_sel;

    always #5 clk = ~clk;

    hazard_unit #(.NBE(NBE), .LD_STG(LD_STG), .SW(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_id    (ir_id),
        .ir_be    (ir_be),
        .bus_busy (bus_busy),
        .amo_req  (amo_req),
        .amo_ack  (amo_ack),
        .stall_if (stall_if),
        .stall_fe (stall_fe),
        .stall_be (stall_be),
        .fw_a_en  (fw_a_en),
        .fw_a_sel (fw_a_sel),
        .fw_b_en  (fw_b_en),
        .fw_b_sel (fw_b_sel)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    // ---------------- table vectors (back end fully valid) ----------------
    typedef struct {
        logic [31:0] id;
        logic [31:0] be0;
        logic [31:0] be1;
        logic [31:0] be2;
        bit          bb;
        bit          ar;
        bit          aa;
        bit          fe;
        bit          sif;
        logic [2:0]  sbe;
        bit          a_en;
        int          a_sel;
        bit          b_en;
        int          b_sel;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] id, input logic [31:0] be0,
                                input logic [31:0] be1, input logic [31:0] be2,
                                input bit bb, input bit ar, input bit aa,
                                input bit fe, input bit sif, input logic [2:0] sbe,
                                input bit a_en, input int a_sel, input bit b_en, input int b_sel);
        vec_t v;
        v.id = id; v.be0 = be0; v.be1 = be1; v.be2 = be2;
        v.bb = bb; v.ar = ar; v.aa = aa;
        v.fe = fe; v.sif = sif; v.sbe = sbe;
        v.a_en = a_en; v.a_sel = a_sel; v.b_en = b_en; v.b_sel = b_sel;
        return v;
    endfunction

    task automatic drive_idle();
        rst_n    = 1'b1;
        bus_busy = 1'b0;
        amo_req  = 1'b0;
        amo_ack  = 1'b0;
        ir_id    = NOP;
        ir_be    = {NBE{NOP}};
    endtask

    task automatic flush();
        @(negedge clk);
        drive_idle();
        repeat (NBE) @(posedge clk);
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] p_ir [NBE];
    bit          p_v  [NBE];
    logic [31:0] id_ir;
    bit          m_a_en, m_b_en;
    int          m_a_sel, m_b_sel;

    function automatic bit is_producer(input int k);
        return p_v[k] && p_ir[k][6:0] != OP_BR && p_ir[k][6:0] != OP_ST && p_ir[k][11:7] != 5'd0;
    endfunction

    function automatic bit late_load(input int k);
        return p_ir[k][6:0] == OP_LD && k < LD_STG;
    endfunction

    function automatic void model_eval(output bit hz, output bit ma, output int ka,
                                       output bit mb, output int kb);
        logic [6:0] op;
        logic [4:0] rs1, rs2;
        bit use1, use2;
        op   = id_ir[6:0];
        rs1  = id_ir[19:15];
        rs2  = id_ir[24:20];
        use1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        use2 = (op == OP_R || op == OP_RW || op == OP_BR || op == OP_ST);
        ma = 0; mb = 0; ka = 0; kb = 0;
        for (int k = 0; k < NBE; k++) begin
            if (!ma && is_producer(k) && p_ir[k][11:7] == rs1) begin ma = 1; ka = k; end
            if (!mb && is_producer(k) && p_ir[k][11:7] == rs2) begin mb = 1; kb = k; end
        end
        hz = (use1 && ma && late_load(ka)) || (use2 && mb && late_load(kb));
        if (!BRFW && (op == OP_BR || op == OP_JALR || op == OP_ST) && ((use1 && ma) || (use2 && mb)))
            hz = 1;
    endfunction

    // One clock of the modelled pipeline; nxt enters ID when ID advances
    task automatic step(input bit rn, input bit bb, input bit ar, input bit aa,
                        input logic [31:0] nxt, output bit adv, output bit sfe,
                        output logic [2:0] sbe);
        bit hz, ma, mb, sall;
        int ka, kb;
        logic [2:0] ebe;
        @(negedge clk);
        rst_n = rn; bus_busy = bb; amo_req = ar; amo_ack = aa;
        ir_id = id_ir;
        for (int k = 0; k < NBE; k++) ir_be[k*32 +: 32] = p_v[k] ? p_ir[k] : $urandom();
        #1;
        model_eval(hz, ma, ka, mb, kb);
        sall = !rn || bb || (ar && !aa);
        for (int k = 0; k < NBE; k++) ebe[k] = sall || !p_v[k];
        check("stall_fe", 32'(stall_fe), 32'(sall || hz));
        check("stall_if", 32'(stall_if), 32'(sall || hz || ar));
        check("stall_be", 32'(stall_be), 32'(ebe));
        sfe = stall_fe;
        sbe = stall_be;
        adv = 0;
        if (!rn) begin
            m_a_en = 0; m_b_en = 0; m_a_sel = 0; m_b_sel = 0;
            for (int k = 0; k < NBE; k++) p_v[k] = 0;
        end else if (!sall) begin
            if (hz) begin
                m_a_en = 0; m_b_en = 0;
            end else begin
                m_a_en = ma; m_b_en = mb;
                if (ma) m_a_sel = ka;
                if (mb) m_b_sel = kb;
            end
            for (int k = NBE - 1; k > 0; k--) begin p_ir[k] = p_ir[k-1]; p_v[k] = p_v[k-1]; end
            if (hz) begin
                p_v[0] = 0;
            end else begin
                p_ir[0] = id_ir; p_v[0] = 1; id_ir = nxt; adv = 1;
            end
        end
        @(posedge clk);
        #1;
        check("fw_a_en", 32'(fw_a_en), 32'(m_a_en));
        if (m_a_en) check("fw_a_sel", 32'(fw_a_sel), 32'(m_a_sel));
        check("fw_b_en", 32'(fw_b_en), 32'(m_b_en));
        if (m_b_en) check("fw_b_sel", 32'(fw_b_sel), 32'(m_b_sel));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  op;
        logic [31:0] r;
        case ($urandom_range(0, 9))
            0: op = OP_R;     1: op = OP_RW;  2: op = OP_I;   3: op = OP_LD;
            4: op = OP_ST;    5: op = OP_BR;  6: op = OP_LUI; 7: op = OP_AUIPC;
            8: op = OP_JAL;   default: op = OP_JALR;
        endcase
        r = $urandom();
        return enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
               | {r[31:25], 10'd0, r[14:12], 12'd0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        bit adv, sfe;
        logic [2:0] sbe;
        logic [2:0] rel_exp [4];
        int cnt;

        // ---------------- reset state ----------------
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall_fe", 32'(stall_fe), 32'd1);
        check("rst_stall_if", 32'(stall_if), 32'd1);
        check("rst_stall_be", 32'(stall_be), 32'b111);
        check("rst_fw_a_en", 32'(fw_a_en), 32'd0);
        check("rst_fw_b_en", 32'(fw_b_en), 32'd0);
        check("rst_fw_a_sel", 32'(fw_a_sel), 32'd0);
        check("rst_fw_b_sel", 32'(fw_b_sel), 32'd0);
        flush();

        // ---------------- table vectors ----------------
        tbl.push_back(mk(enc(OP_R,6,5,7), enc(OP_R,5,1,2), NOP, NOP, 0,0,0, 0,0,3'b000, 1,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,5), enc(OP_LD,5,1,0), NOP, NOP, 0,0,0, 1,1,3'b000, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,5), NOP, enc(OP_LD,5,1,0), NOP, 0,0,0, 1,1,3'b000, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,5), NOP, NOP, enc(OP_LD,5,1,0), 0,0,0, 0,0,3'b000, 1,2, 1,2));
        tbl.push_back(mk(enc(OP_R,8,0,5), enc(OP_I,5,1,0), enc(OP_I,5,0,0), NOP, 0,0,0, 0,0,3'b000, 0,0, 1,0));
        tbl.push_back(mk(enc(OP_R,6,0,0), enc(OP_I,0,1,0), NOP, NOP, 0,0,0, 0,0,3'b000, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,7), enc(OP_R,5,1,2), NOP, NOP, 1,0,0, 1,1,3'b111, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,7), enc(OP_R,5,1,2), NOP, NOP, 0,1,0, 1,1,3'b111, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,7), enc(OP_R,5,1,2), NOP, NOP, 0,1,1, 0,1,3'b000, 1,0, 0,0));
        tbl.push_back(mk(enc(OP_BR,0,5,0), enc(OP_I,5,0,0), NOP, NOP, 0,0,0, !BRFW,!BRFW,3'b000, BRFW,0, 0,0));
        tbl.push_back(mk(enc(OP_ST,0,6,5), NOP, NOP, enc(OP_I,5,0,0), 0,0,0, !BRFW,!BRFW,3'b000, 0,0, BRFW,2));
        tbl.push_back(mk(enc(OP_JALR,1,5,0), NOP, NOP, enc(OP_I,5,0,0), 0,0,0, !BRFW,!BRFW,3'b000, BRFW,2, 0,0));
        tbl.push_back(mk(enc(OP_R,6,5,0), enc(OP_ST,5,1,2), enc(OP_BR,5,1,2), NOP, 0,0,0, 0,0,3'b000, 0,0, 0,0));
        tbl.push_back(mk(enc(OP_R,9,7,7), enc(OP_I,7,1,0), enc(OP_LD,7,1,0), NOP, 0,0,0, 0,0,3'b000, 1,0, 1,0));
        tbl.push_back(mk(enc(OP_RW,6,1,5), enc(OP_LD,5,1,0), NOP, NOP, 0,0,0, 1,1,3'b000, 0,0, 0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            ir_id = tbl[i].id;
            ir_be = {tbl[i].be2, tbl[i].be1, tbl[i].be0};
            bus_busy = tbl[i].bb; amo_req = tbl[i].ar; amo_ack = tbl[i].aa;
            #1;
            check($sformatf("v%0d_stall_fe", i), 32'(stall_fe), 32'(tbl[i].fe));
            check($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(tbl[i].sif));
            check($sformatf("v%0d_stall_be", i), 32'(stall_be), 32'(tbl[i].sbe));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_fw_a_en", i), 32'(fw_a_en), 32'(tbl[i].a_en));
            if (tbl[i].a_en) check($sformatf("v%0d_fw_a_sel", i), 32'(fw_a_sel), 32'(tbl[i].a_sel));
            check($sformatf("v%0d_fw_b_en", i), 32'(fw_b_en), 32'(tbl[i].b_en));
            if (tbl[i].b_en) check($sformatf("v%0d_fw_b_sel", i), 32'(fw_b_sel), 32'(tbl[i].b_sel));
            flush();
        end

        // ---------------- reset release sequence ----------------
        id_ir = NOP;
        for (int k = 0; k < NBE; k++) begin p_ir[k] = NOP; p_v[k] = 0; end
        m_a_en = 0; m_b_en = 0; m_a_sel = 0; m_b_sel = 0;
        step(0, 0, 0, 0, NOP, adv, sfe, sbe);
        step(0, 0, 0, 0, NOP, adv, sfe, sbe);
        check("rst_hold_be", 32'(sbe), 32'b111);
        rel_exp[0] = 3'b111; rel_exp[1] = 3'b110; rel_exp[2] = 3'b100; rel_exp[3] = 3'b000;
        for (int n = 0; n < 4; n++) begin
            step(1, 0, 0, 0, NOP, adv, sfe, sbe);
            check($sformatf("release_be%0d", n), 32'(sbe), 32'(rel_exp[n]));
        end

        // ---------------- load-use ----------------
        step(1, 0, 0, 0, enc(OP_LD,5,1,0), adv, sfe, sbe);
        step(1, 0, 0, 0, enc(OP_R,6,5,5), adv, sfe, sbe);
        cnt = 0; adv = 0;
        for (int n = 0; n < 20 && !adv; n++) begin
            step(1, 0, 0, 0, NOP, adv, sfe, sbe);
            if (sfe) cnt++;
        end
        check("luse_adv", 32'(adv), 32'd1);
        check("luse_stalls", 32'(cnt), 32'd2);
        check("luse_fw_a_en", 32'(fw_a_en), 32'd1);
        check("luse_fw_a_sel", 32'(fw_a_sel), 32'd2);
        check("luse_fw_b_en", 32'(fw_b_en), 32'd1);
        check("luse_fw_b_sel", 32'(fw_b_sel), 32'd2);
        repeat (NBE) step(1, 0, 0, 0, NOP, adv, sfe, sbe);

        // ---------------- load-use with bus stall in the middle ----------------
        step(1, 0, 0, 0, enc(OP_LD,5,1,0), adv, sfe, sbe);
        step(1, 0, 0, 0, enc(OP_R,6,5,5), adv, sfe, sbe);
        cnt = 0; adv = 0;
        for (int n = 0; n < 20 && !adv; n++) begin
            bit bb;
            bb = (n >= 1 && n <= 3);
            step(1, bb, 0, 0, NOP, adv, sfe, sbe);
            if (sfe && !bb) cnt++;
        end
        check("bus_luse_adv", 32'(adv), 32'd1);
        check("bus_luse_bubbles", 32'(cnt), 32'd2);
        check("bus_luse_fw_a_sel", 32'(fw_a_sel), 32'd2);
        check("bus_luse_fw_b_en", 32'(fw_b_en), 32'd1);
        repeat (NBE) step(1, 0, 0, 0, NOP, adv, sfe, sbe);

        // ---------------- branch consumer ----------------
        step(1, 0, 0, 0, enc(OP_I,5,0,0), adv, sfe, sbe);
        step(1, 0, 0, 0, enc(OP_BR,0,5,0), adv, sfe, sbe);
        cnt = 0; adv = 0;
        for (int n = 0; n < 20 && !adv; n++) begin
            step(1, 0, 0, 0, NOP, adv, sfe, sbe);
            if (sfe) cnt++;
        end
        check("br_adv", 32'(adv), 32'd1);
        check("br_stalls", 32'(cnt), BRFW ? 32'd0 : 32'd3);
        check("br_fw_a_en", 32'(fw_a_en), 32'(BRFW));
        repeat (NBE) step(1, 0, 0, 0, NOP, adv, sfe, sbe);

        // ---------------- randomized run ----------------
        for (int n = 0; n < 3000; n++) begin
            bit rn, bb, ar, aa;
            rn = ($urandom_range(0, 99) != 0);
            bb = ($urandom_range(0, 7) == 0);
            ar = ($urandom_range(0, 5) == 0);
            aa = ($urandom_range(0, 1) == 1);
            step(rn, bb, ar, aa, rand_instr(), adv, sfe, sbe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
